// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus serializer/deserializer pair.
package serial_bus_pkg;

  typedef enum logic {IDLE, SHIFT} p2s_state_t;

  // Counter width for a mod-w counter, never narrower than one bit.
  function automatic int cnt_w(int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/parallel_to_serial_beat_counter.sv
// beat_counter: mod-MAX beat counter with synchronous clear, enable and a terminal-count flag.
module beat_counter
  import serial_bus_pkg::*;
#(
  parameter int unsigned MAX = 8,
  parameter int unsigned CW  = unsigned'(cnt_w(int'(MAX)))
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          is_last
);

  assign is_last = (cnt == CW'(MAX - 1));

  // Wrap is explicit so non-power-of-two MAX never reaches MAX.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= is_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Serializer: one IN_WIDTH-bit word in, one bit per accepted beat out, back-to-back capable.
// Optional m_last output enabled by defining PARALLEL_TO_SERIAL_LAST_EN.
module parallel_to_serial
  import serial_bus_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_data
`ifdef PARALLEL_TO_SERIAL_LAST_EN
  ,
  output logic                m_last
`endif
);

  localparam int unsigned CW = unsigned'(cnt_w(int'(IN_WIDTH)));

  p2s_state_t          state_q, state_d;
  logic [IN_WIDTH-1:0] shift_ff, shift_nxt;
  logic [CW-1:0]       cnt;
  logic                cnt_last;
  logic                bit_hs, word_hs, last_beat;

  assign m_valid   = (state_q == SHIFT);
  assign bit_hs    = m_valid & m_ready;
  assign last_beat = bit_hs & cnt_last;
  // m_ready reaches s_ready combinationally so words stream with no idle beat.
  assign s_ready   = (state_q == IDLE) | last_beat;
  assign word_hs   = s_valid & s_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign m_data    = shift_ff[IN_WIDTH-1];
      assign shift_nxt = {shift_ff[IN_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign m_data    = shift_ff[0];
      assign shift_nxt = {1'b0, shift_ff[IN_WIDTH-1:1]};
    end
  endgenerate

`ifdef PARALLEL_TO_SERIAL_LAST_EN
  assign m_last = m_valid & cnt_last;
`endif

  beat_counter #(
    .MAX (IN_WIDTH),
    .CW  (CW)
  ) u_beat_counter (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (word_hs),
    .en      (bit_hs),
    .cnt     (cnt),
    .is_last (cnt_last)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (s_valid) state_d = SHIFT;
      SHIFT: begin
        if (word_hs) begin
          state_d = SHIFT;
        end else if (last_beat) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // A new word takes priority over shifting out the last bit of the old one.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift_ff <= '0;
    end else if (word_hs) begin
      shift_ff <= s_data;
    end else if (bit_hs) begin
      shift_ff <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: 8-bit LSB-first and 5-bit MSB-first instances.
`timescale 1ns/1ps
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       s_valid, s_ready, m_valid, m_ready, m_data;
  logic [7:0] s_data;
  logic       s5_valid, s5_ready, m5_valid, m5_ready, m5_data;
  logic [4:0] s5_data;
`ifdef PARALLEL_TO_SERIAL_LAST_EN
  logic       m_last, m5_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.IN_WIDTH(8), .MSB_FIRST(1'b0)) u_dut (
    .clk     (clk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    ,
    .m_last  (m_last)
`endif
  );

  parallel_to_serial #(.IN_WIDTH(5), .MSB_FIRST(1'b1)) u_dut5 (
    .clk     (clk),
    .aresetn (aresetn),
    .s_valid (s5_valid),
    .s_ready (s5_ready),
    .s_data  (s5_data),
    .m_valid (m5_valid),
    .m_ready (m5_ready),
    .m_data  (m5_data)
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    ,
    .m_last  (m5_last)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s5_valid = 1'b0; s5_data = '0; m5_ready = 1'b0;
    #3;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: m_valid=%b m_data=%b s_ready=%b expected 0 0 1", m_valid, m_data, s_ready);
    end
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] exp = 8'b1010_0101;
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
    step();
    s_valid = 1'b0; s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        errors++;
        $display("FAIL single_bit%0d: m_valid=%b m_data=%b expected 1 %b", i, m_valid, m_data, exp[i]);
      end
      step();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp = 16'hFF01;
    s_valid = 1'b1; s_data = 8'h01; m_ready = 1'b1;
    step();
    s_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i] || s_ready !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b_beat%0d: m_valid=%b m_data=%b s_ready=%b expected 1 %b %b",
                 i, m_valid, m_data, s_ready, exp[i], (i == 7 || i == 15));
      end
      step();
      if (i == 7) s_valid = 1'b0;
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp = 8'b0011_1100;
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        errors++;
        $display("FAIL bp_pre%0d: m_valid=%b m_data=%b expected 1 %b", i, m_valid, m_data, exp[i]);
      end
      step();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 1'b1 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: m_valid=%b m_data=%b s_ready=%b expected 1 1 0", i, m_valid, m_data, s_ready);
      end
      step();
    end
    m_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        errors++;
        $display("FAIL bp_post%0d: m_valid=%b m_data=%b expected 1 %b", i, m_valid, m_data, exp[i]);
      end
      step();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp = 8'b0000_1111;
    s_valid = 1'b1; s_data = 8'hF0; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst: m_valid=%b m_data=%b s_ready=%b expected 0 0 1", m_valid, m_data, s_ready);
    end
    step();
    aresetn = 1'b1;
    step();
    s_valid = 1'b1; s_data = 8'h0F;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        errors++;
        $display("FAIL midrst_bit%0d: m_valid=%b m_data=%b expected 1 %b", i, m_valid, m_data, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_msb_first_w5();
    logic [9:0] exp = 10'b01011_01001;
    logic [4:0] rdy = 5'b10000;
    s5_valid = 1'b1; s5_data = 5'b10010; m5_ready = 1'b1;
    step();
    s5_data = 5'b11010;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (m5_valid !== 1'b1 || m5_data !== exp[i] || s5_ready !== rdy[i % 5]) begin
        errors++;
        $display("FAIL w5_beat%0d: m_valid=%b m_data=%b s_ready=%b expected 1 %b %b",
                 i, m5_valid, m5_data, s5_ready, exp[i], rdy[i % 5]);
      end
      step();
      if (i == 4) s5_valid = 1'b0;
    end
    checks++;
    if (m5_valid !== 1'b0) begin
      errors++;
      $display("FAIL w5_end: m_valid=%b expected 0", m5_valid);
    end
  endtask

`ifdef PARALLEL_TO_SERIAL_LAST_EN
  task automatic test_last();
    s_valid = 1'b1; s_data = 8'h80; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (m_last !== 1'b0 || m_data !== 1'b0) begin
        errors++;
        $display("FAIL last_early%0d: m_last=%b m_data=%b expected 0 0", i, m_last, m_data);
      end
      step();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_last !== 1'b1 || m_data !== 1'b1 || m_valid !== 1'b1) begin
        errors++;
        $display("FAIL last_hold%0d: m_last=%b m_data=%b m_valid=%b expected 1 1 1", i, m_last, m_data, m_valid);
      end
      step();
    end
    m_ready = 1'b1;
    step();
    checks++;
    if (m_last !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_end: m_last=%b m_valid=%b expected 0 0", m_last, m_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_msb_first_w5();
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    test_last();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
